// File: rtl/io_key_sw_ctrl.sv
// KEY/SW input conditioner: 2-flop sync, per-bit debounce, sticky ready/overrun status registers.
// Optional macro IO_KEY_IRQ_EN adds a KEY interrupt enable (KCTRL bit 8) and the irq output.
module io_key_sw_ctrl #(
    parameter int unsigned      DBITS           = 32,
    parameter int unsigned      KEY_BITS        = 4,
    parameter int unsigned      SW_BITS         = 10,
    parameter int unsigned      DEBOUNCE_CYCLES = 100000,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_SWCTRL     = 32'hF0000114
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] KEY,
    input  logic [SW_BITS-1:0]  SW,
    input  logic [DBITS-1:0]    addr,
    input  logic                we,
    input  logic                re,
    input  logic [DBITS-1:0]    wdata,
    output logic [DBITS-1:0]    rdata,
    output logic                sel
`ifdef IO_KEY_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int unsigned N  = KEY_BITS + SW_BITS;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  raw, sync1_q, sync2_q, stable_q, stable_d, upd;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    logic hit_key, hit_sw, hit_kctrl, hit_swctrl;
    logic rd_key, rd_sw, k_chg, sw_chg;
    logic k_ready_q, k_ready_d, k_ovr_q, k_ovr_d;
    logic s_ready_q, s_ready_d, s_ovr_q, s_ovr_d;
    logic ie_rd;
    logic unused_wdata;

    // Keys are inverted so internal 1 = pressed; KEY occupies the low bits.
    assign raw = {SW, ~KEY};

    always_comb begin
        stable_d = stable_q;
        upd      = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                    upd[i]      = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign k_chg  = |upd[KEY_BITS-1:0];
    assign sw_chg = |upd[N-1:KEY_BITS];

    assign hit_key    = (addr == ADDR_KEY);
    assign hit_sw     = (addr == ADDR_SW);
    assign hit_kctrl  = (addr == ADDR_KCTRL);
    assign hit_swctrl = (addr == ADDR_SWCTRL);
    assign rd_key     = re & hit_key;
    assign rd_sw      = re & hit_sw;

    // A change coinciding with a data read keeps ready set and does not flag overrun.
    always_comb begin
        k_ready_d = k_chg ? 1'b1 : (rd_key ? 1'b0 : k_ready_q);
        s_ready_d = sw_chg ? 1'b1 : (rd_sw ? 1'b0 : s_ready_q);
        k_ovr_d   = k_ovr_q;
        s_ovr_d   = s_ovr_q;
        if (we && hit_kctrl && !wdata[1])  k_ovr_d = 1'b0;
        if (we && hit_swctrl && !wdata[1]) s_ovr_d = 1'b0;
        if (k_chg && k_ready_q && !rd_key) k_ovr_d = 1'b1;
        if (sw_chg && s_ready_q && !rd_sw) s_ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            k_ready_q <= 1'b0;
            k_ovr_q   <= 1'b0;
            s_ready_q <= 1'b0;
            s_ovr_q   <= 1'b0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            k_ready_q <= k_ready_d;
            k_ovr_q   <= k_ovr_d;
            s_ready_q <= s_ready_d;
            s_ovr_q   <= s_ovr_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef IO_KEY_IRQ_EN
    logic ie_q, irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (we && hit_kctrl) ie_q <= wdata[8];
            irq_q <= k_ready_q & ie_q;
        end
    end

    assign ie_rd = ie_q;
    assign irq   = irq_q;
`else
    assign ie_rd = 1'b0;
`endif

    assign unused_wdata = ^{wdata[DBITS-1:2], wdata[0]};

    always_comb begin
        rdata = '0;
        sel   = 1'b0;
        if (hit_key) begin
            sel   = 1'b1;
            rdata = DBITS'(stable_q[KEY_BITS-1:0]);
        end else if (hit_sw) begin
            sel   = 1'b1;
            rdata = DBITS'(stable_q[N-1:KEY_BITS]);
        end else if (hit_kctrl) begin
            sel      = 1'b1;
            rdata[0] = k_ready_q;
            rdata[1] = k_ovr_q;
            rdata[8] = ie_rd;
        end else if (hit_swctrl) begin
            sel      = 1'b1;
            rdata[0] = s_ready_q;
            rdata[1] = s_ovr_q;
        end
    end

endmodule

// File: tb/tb_io_key_sw_ctrl.sv
// Directed self-checking bench for io_key_sw_ctrl with DEBOUNCE_CYCLES = 4.
module tb_io_key_sw_ctrl;

    localparam logic [31:0] A_KEY    = 32'hF0000010;
    localparam logic [31:0] A_SW     = 32'hF0000014;
    localparam logic [31:0] A_KCTRL  = 32'hF0000110;
    localparam logic [31:0] A_SWCTRL = 32'hF0000114;
    localparam logic [31:0] A_NONE   = 32'hF0000020;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [31:0] addr, wdata, rdata;
    logic        we, re, sel;
`ifdef IO_KEY_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    io_key_sw_ctrl #(
        .DBITS(32), .KEY_BITS(4), .SW_BITS(10), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .KEY   (KEY),
        .SW    (SW),
        .addr  (addr),
        .we    (we),
        .re    (re),
        .wdata (wdata),
        .rdata (rdata),
        .sel   (sel)
`ifdef IO_KEY_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic load(input logic [31:0] a);
        addr = a; re = 1'b1;
        tick(1);
        re = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick(1);
        we = 1'b0; wdata = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; KEY = 4'hF; SW = '0; addr = A_NONE; we = 0; re = 0; wdata = '0;
        tick(3);
        reset = 1'b0;
        tick(20);
        peek(A_KEY, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_kdata got %h want %h", d, 32'h0); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL reset_sel_key got %b want 1", sel); end
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_kctrl got %h want %h", d, 32'h0); end
        peek(A_SWCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_swctrl got %h want %h", d, 32'h0); end
        peek(A_NONE, d);
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL unmapped_sel got %b want 0", sel); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rdata got %h want 0", d); end
    endtask

    task automatic test_debounce_latency();
        logic [31:0] d;
        KEY = 4'b1011;
        tick(5);
        peek(A_KEY, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL key_at_5_edges got %h want 0", d); end
        tick(1);
        peek(A_KEY, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL key_at_6_edges got %h want 4", d); end
        tick(4);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL kctrl_ready got %h want 1", d); end
        load(A_KEY);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL kctrl_after_load got %h want 0", d); end
        KEY = 4'hF;
        tick(8);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL kctrl_after_release got %h want 1", d); end
        load(A_KEY);
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        SW = 10'h001;
        tick(3);
        SW = 10'h000;
        tick(10);
        peek(A_SW, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_swdata got %h want 0", d); end
        peek(A_SWCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_swctrl got %h want 0", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        KEY = 4'b1110;
        tick(8);
        KEY = 4'hF;
        tick(8);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL kctrl_overrun got %h want 3", d); end
        store(A_KCTRL, 32'h2);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL kctrl_wr_bit1_set got %h want 3", d); end
        store(A_KCTRL, 32'h0);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL kctrl_ovr_clear got %h want 1", d); end
        load(A_KEY);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL kctrl_final got %h want 0", d); end
    endtask

    task automatic test_coincide();
        logic [31:0] d;
        KEY = 4'b0111;
        tick(5);
        load(A_KEY);  // edge 6: stable change and data read together
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL coincide_kctrl got %h want 1", d); end
        peek(A_KEY, d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL coincide_kdata got %h want 8", d); end
        KEY = 4'hF;
        tick(8);
        store(A_KCTRL, 32'h0);
        load(A_KEY);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL coincide_cleanup got %h want 0", d); end
    endtask

    task automatic test_write_ignored();
        logic [31:0] d;
        store(A_KEY, 32'hFFFF_FFFF);
        store(A_SW, 32'hFFFF_FFFF);
        peek(A_KEY, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL kdata_write_ignored got %h want 0", d); end
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL kctrl_after_data_write got %h want 0", d); end
    endtask

    task automatic test_sw_path();
        logic [31:0] d;
        SW = 10'h2A5;
        tick(8);
        peek(A_SW, d);
        checks++; if (d !== 32'h2A5) begin errors++; $display("FAIL swdata got %h want 2a5", d); end
        peek(A_SWCTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL swctrl_ready got %h want 1", d); end
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL kctrl_isolated got %h want 0", d); end
        SW = 10'h000;
        tick(8);
        peek(A_SWCTRL, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL swctrl_overrun got %h want 3", d); end
        store(A_SWCTRL, 32'h0);
        peek(A_SWCTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL swctrl_ovr_clear got %h want 1", d); end
        load(A_SW);
        peek(A_SWCTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL swctrl_after_load got %h want 0", d); end
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] d;
        KEY = 4'b1101;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        peek(A_KEY, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_5_edges got %h want 0", d); end
        tick(1);
        peek(A_KEY, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL rst_mid_6_edges got %h want 2", d); end
        KEY = 4'hF;
        tick(8);
        store(A_KCTRL, 32'h0);
        load(A_KEY);
    endtask

`ifdef IO_KEY_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        store(A_KCTRL, 32'h100);
        peek(A_KCTRL, d);
        checks++; if (d !== 32'h100) begin errors++; $display("FAIL kctrl_ie got %h want 100", d); end
        KEY = 4'b1101;
        tick(6);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_at_ready got %b want 0", irq); end
        tick(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_ready got %b want 1", irq); end
        load(A_KEY);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_load got %b want 1", irq); end
        tick(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_load got %b want 0", irq); end
    endtask
`endif

    initial begin
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_overrun();
        test_coincide();
        test_write_ignored();
        test_sw_path();
        test_reset_mid_debounce();
`ifdef IO_KEY_IRQ_EN
        test_irq();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
